// File: rtl/cve2_pkg.sv
// cve2 core package: writeback-stage types.
//   wb_state_e : occupancy of the single writeback slot.
//   wb_entry_t : fields captured from ID when an instruction enters writeback.
// The entry is sized for the widest legal configuration (32-bit data, 5-bit
// register address, up to 4 result channels); narrower instances zero-extend.
package cve2_pkg;

  localparam int unsigned WbDataW = 32;
  localparam int unsigned WbAddrW = 5;
  localparam int unsigned WbSelW  = 2;

  typedef enum logic [1:0] {
    WB_EMPTY,
    WB_WAIT,
    WB_DONE
  } wb_state_e;

  typedef struct packed {
    logic               we;
    logic [WbAddrW-1:0] waddr;
    logic [WbDataW-1:0] wdata;
    logic [WbSelW-1:0]  sel;
    logic               compressed;
    logic               perf;
  } wb_entry_t;

endpackage

// File: rtl/cve2_wb_stage.sv
// cve2 registered writeback stage.
// Holds one retiring instruction and writes the register file from either the
// ID/EX result captured at accept (channel 0) or a late result channel.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   id_*                              retiring instruction from ID/EX
//   wb_ready_o                        slot can take an instruction this cycle
//   src_resp_valid_i/err_i/wdata_i    late result channels (bit/lane 0 unused)
//   rf_we_o/rf_waddr_o/rf_wdata_o     register file write port
//   pending_o/pending_addr_o          outstanding late write, for ID stalls
//   perf_instr_ret_o(_compressed_o)   retire pulses
//   wb_err_o                          awaited channel answered with an error
module cve2_wb_stage
  import cve2_pkg::*;
#(
  parameter int unsigned NumSrc    = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             id_valid_i,
  output logic                             wb_ready_o,
  input  logic [$clog2(NumSrc)-1:0]        id_src_sel_i,
  input  logic [AddrWidth-1:0]             id_waddr_i,
  input  logic                             id_we_i,
  input  logic [DataWidth-1:0]             id_wdata_i,
  input  logic                             id_is_compressed_i,
  input  logic                             id_perf_count_i,
  input  logic [NumSrc-1:0]                src_resp_valid_i,
  input  logic [NumSrc-1:0]                src_resp_err_i,
  input  logic [NumSrc-1:0][DataWidth-1:0] src_wdata_i,
  output logic                             rf_we_o,
  output logic [AddrWidth-1:0]             rf_waddr_o,
  output logic [DataWidth-1:0]             rf_wdata_o,
  output logic                             pending_o,
  output logic [AddrWidth-1:0]             pending_addr_o,
  output logic                             perf_instr_ret_o,
  output logic                             perf_instr_ret_compressed_o,
  output logic                             wb_err_o
);

  localparam int unsigned SelW = $clog2(NumSrc);

  wb_state_e           state_p1, state_d;
  wb_entry_t           entry_p1, entry_d;
  logic [SelW-1:0]     sel_p1;
  logic                in_wait, in_done, resp_hit, resp_err, complete_ok;
  logic                dest_ok, wr_en, accept;
  logic [DataWidth-1:0] wdata_mux;
  logic [NumSrc-1:0]   stray;

  assign sel_p1  = entry_p1.sel[SelW-1:0];
  assign in_wait = (state_p1 == WB_WAIT);
  assign in_done = (state_p1 == WB_DONE);

  // Late results only match once the entry sits in WAIT, so a response in the
  // accept cycle is never taken.
  assign resp_hit    = in_wait & src_resp_valid_i[sel_p1];
  assign resp_err    = resp_hit & src_resp_err_i[sel_p1];
  assign complete_ok = in_done | (resp_hit & ~resp_err);

  // x0 is hardwired; the instruction still retires.
  assign dest_ok = entry_p1.we & (entry_p1.waddr != '0);
  assign wr_en   = complete_ok & dest_ok;

  assign wb_ready_o = (state_p1 == WB_EMPTY) | in_done | resp_hit;
  assign accept     = id_valid_i & wb_ready_o;

  // Late data is forwarded combinationally so the write lands in the
  // response cycle.
  assign wdata_mux = in_done ? DataWidth'(entry_p1.wdata) : src_wdata_i[sel_p1];

  assign rf_we_o    = wr_en;
  assign rf_waddr_o = wr_en ? AddrWidth'(entry_p1.waddr) : '0;
  assign rf_wdata_o = wr_en ? wdata_mux : '0;

  assign pending_o      = in_wait & dest_ok;
  assign pending_addr_o = pending_o ? AddrWidth'(entry_p1.waddr) : '0;

  assign perf_instr_ret_o            = complete_ok & entry_p1.perf;
  assign perf_instr_ret_compressed_o = perf_instr_ret_o & entry_p1.compressed;
  assign wb_err_o                    = resp_err;

  always_comb begin
    entry_d            = entry_p1;
    entry_d.we         = id_we_i;
    entry_d.waddr      = WbAddrW'(id_waddr_i);
    entry_d.wdata      = WbDataW'(id_wdata_i);
    entry_d.sel        = WbSelW'(id_src_sel_i);
    entry_d.compressed = id_is_compressed_i;
    entry_d.perf       = id_perf_count_i;
  end

  // The outgoing entry completes in the same cycle the next one is captured.
  always_comb begin
    state_d = WB_EMPTY;
    if (accept) begin
      state_d = (id_src_sel_i == '0) ? WB_DONE : WB_WAIT;
    end else if (in_wait && !resp_hit) begin
      state_d = WB_WAIT;
    end
  end

  // ---- stage p1: writeback slot ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1 <= WB_EMPTY;
    end else begin
      state_p1 <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      entry_p1 <= entry_d;
    end
  end

  always_comb begin
    stray = '0;
    for (int c = 1; c < NumSrc; c++) begin
      stray[c] = src_resp_valid_i[c] & ~(in_wait & (SelW'(c) == sel_p1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0({in_done & dest_ok, resp_hit & ~resp_err & dest_ok}))
        else $error("more than one writeback source active");
      assert (stray == '0)
        else $warning("stray result response ignored");
    end
  end

  // ID must hold a stalled instruction unchanged until it is accepted.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (id_valid_i && !wb_ready_o) |=> (id_valid_i && $stable({id_src_sel_i, id_waddr_i,
      id_we_i, id_wdata_i, id_is_compressed_i, id_perf_count_i})))
    else $error("ID changed a stalled instruction");

endmodule
